pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised successor to the combinational next-PC logic: owns the fetch PC register and resolves the next PC in the D stage.
- Handles jumps, six branch conditions, branch-likely delay-slot annulment, exception and eret redirects, and stalls.
- Flags fetch address errors and keeps saturating branch statistics counters.
- Sits between F (IM address) and D (comparator operands from forwarded GPRs).

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VEC, 32'h0000_4180, exception handler entry
IMEM_END, 32'h0000_6ffc, highest legal fetch address (inclusive)
LIKELY_EN, 1, 1 = honour likely input; 0 = likely ignored, flush_f never asserted for branches
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
stall  in  1  hold PC and counters (hazard unit)
d_pc4  in  32  PC+4 of instruction in D
br_type  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (= none)
likely  in  1  D branch is a likely variant
cmp1  in  32  rs value (forwarded)
cmp2  in  32  rt value (forwarded)
imm16  in  16  branch offset field
jump  in  1  j/jal in D
imm26  in  26  jump index
jr  in  1  jr/jalr in D
jr_target  in  32  register target
exc_req  in  1  exception taken this cycle
eret  in  1  eret in D
epc  in  32  return address from CP0
f_pc  out  32  current fetch PC (registered)
f_pc4  out  32  f_pc + 4
taken  out  1  redirect by branch/jump/jr this cycle
flush_f  out  1  convert instruction in F to nop at next edge
f_adel  out  1  fetch address error
br_cnt  out  CNT_W  branches resolved
br_taken_cnt  out  CNT_W  branches taken

Behaviour:
- Reset (sync): f_pc = RESET_PC; br_cnt = br_taken_cnt = 0. All other outputs are combinational from f_pc and the inputs.
- pc_d = d_pc4 - 4. Branch target = pc_d + (sign_extend(imm16) << 2). Jump target = {pc_d[31:28], imm26, 2'b00}. All arithmetic is 32-bit modulo; wrap-around is not flagged.
- Branch conditions (cmp1/cmp2 signed where relevant):
  - beq: cmp1 == cmp2
  - bne: cmp1 != cmp2
  - blez: cmp1 <= 0
  - bgtz: cmp1 > 0
  - bltz: cmp1 < 0
  - bgez: cmp1 >= 0
- npc priority, highest first:
  1. exc_req → EXC_VEC
  2. eret → epc
  3. jump → jump target
  4. branch with condition true → branch target
  5. jr → jr_target
  6. otherwise f_pc + 4
- Update at clock edge:
  - exc_req or eret: f_pc <= npc even if stall = 1 (redirect overrides stall).
  - otherwise: f_pc <= npc only when stall = 0.
- taken = 1 for priorities 3–5, masked when stall = 1 (operands not yet valid). When stall = 1 and no exc/eret, the normal path selects f_pc + 4 but the PC holds.
- flush_f = exc_req | eret | (LIKELY_EN & likely & br_type in 1..6 & condition false & !stall).
  - Taken likely branch: delay slot executes.
  - Not-taken likely branch: delay slot annulled and fetch continues at f_pc + 4.
- f_adel = (f_pc[1:0] != 0) | (f_pc < RESET_PC) | (f_pc > IMEM_END). f_pc still updates normally; CP0 decides the response.
- Counters, on an edge with !stall & !exc_req & br_type in 1..6:
  - br_cnt += 1.
  - br_taken_cnt += 1 if the condition is true.
  - Both saturate at all-ones with no wrap.
  - exc_req in the same cycle suppresses counting.
- Reset asserted with stall, exc_req or any other input: reset wins; f_pc = RESET_PC next cycle.
- Simultaneous jump and branch (illegal decode): jump wins per priority; counters still count the branch.

Test Plan:
- Reset, then 3 unstalled cycles → f_pc 0x3000, 0x3004, 0x3008, 0x300c; counters 0; f_adel 0.
- d_pc4=0x3010, br_type=1, cmp1=cmp2=5, imm16=0xfffc → f_pc next 0x2ffc; taken=1; br_cnt=1, br_taken_cnt=1; f_adel=1 the following cycle.
- br_type=3 (blez), likely=1, cmp1=1, stall=0 → flush_f=1, taken=0, f_pc advances +4, br_cnt++ only. Repeat with LIKELY_EN=0 → flush_f=0.
- stall=1 with branch true for 2 cycles → f_pc holds, taken=0, counters unchanged. stall drops → redirect once, counters +1.
- stall=1, exc_req=1, jump=1 → f_pc next = 0x4180, flush_f=1, no count. Next, eret=1, epc=0x3020 → f_pc next 0x3020.
- CNT_W=4: 17 taken bgez (cmp1=0) → br_cnt=br_taken_cnt=15 (saturated). jr_target=0x3002 → f_adel=1 next cycle.

Source files
------------

// File: rtl/pc_unit_if.sv
// Bundles the D-stage redirect inputs and fetch-side outputs of pc_unit.
// slave is the pc_unit side; master is the pipeline/bench side.
interface pc_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic [31:0]      d_pc4;
    logic [2:0]       br_type;
    logic             likely;
    logic [31:0]      cmp1;
    logic [31:0]      cmp2;
    logic [15:0]      imm16;
    logic             jump;
    logic [25:0]      imm26;
    logic             jr;
    logic [31:0]      jr_target;
    logic             exc_req;
    logic             eret;
    logic [31:0]      epc;
    logic [31:0]      f_pc;
    logic [31:0]      f_pc4;
    logic             taken;
    logic             flush_f;
    logic             f_adel;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] br_taken_cnt;

    modport master (
        output stall, d_pc4, br_type, likely, cmp1, cmp2, imm16,
               jump, imm26, jr, jr_target, exc_req, eret, epc,
        input  f_pc, f_pc4, taken, flush_f, f_adel, br_cnt, br_taken_cnt
    );

    modport slave (
        input  stall, d_pc4, br_type, likely, cmp1, cmp2, imm16,
               jump, imm26, jr, jr_target, exc_req, eret, epc,
        output f_pc, f_pc4, taken, flush_f, f_adel, br_cnt, br_taken_cnt
    );
endinterface

// File: rtl/pc_unit.sv
// Fetch PC register with D-stage next-PC resolution, likely-branch annulment,
// fetch address-error detection and saturating branch statistics.
module pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter logic [31:0] IMEM_END  = 32'h0000_6ffc,
    parameter bit          LIKELY_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic      clk,
    input  logic      reset,
    pc_unit_if.slave  bus
);

    logic [31:0]      f_pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      br_target;
    logic [31:0]      j_target;
    logic [31:0]      npc;
    logic             is_br;
    logic             cond;
    logic             taken_w;
    logic             redirect;
    logic             count_en;
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] br_taken_cnt_q;

    assign pc_d      = bus.d_pc4 - 32'd4;
    assign br_target = pc_d + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
    assign j_target  = {pc_d[31:28], bus.imm26, 2'b00};
    assign is_br     = (bus.br_type != 3'd0) && (bus.br_type != 3'd7);
    assign redirect  = bus.exc_req | bus.eret;

    // Signed zero comparisons reduce to sign bit and zero test.
    always_comb begin
        cond = 1'b0;
        unique case (bus.br_type)
            3'd1:    cond = (bus.cmp1 == bus.cmp2);
            3'd2:    cond = (bus.cmp1 != bus.cmp2);
            3'd3:    cond = bus.cmp1[31] | (bus.cmp1 == '0);
            3'd4:    cond = !bus.cmp1[31] && (bus.cmp1 != '0);
            3'd5:    cond = bus.cmp1[31];
            3'd6:    cond = !bus.cmp1[31];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        npc     = f_pc_q + 32'd4;
        taken_w = 1'b0;
        if (bus.exc_req) begin
            npc = EXC_VEC;
        end else if (bus.eret) begin
            npc = bus.epc;
        end else if (!bus.stall) begin
            if (bus.jump) begin
                npc     = j_target;
                taken_w = 1'b1;
            end else if (is_br && cond) begin
                npc     = br_target;
                taken_w = 1'b1;
            end else if (bus.jr) begin
                npc     = bus.jr_target;
                taken_w = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q <= RESET_PC;
        end else if (redirect || !bus.stall) begin
            f_pc_q <= npc;
        end
    end

    assign count_en = !bus.stall && !bus.exc_req && is_br;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
        end else if (count_en) begin
            if (br_cnt_q != '1) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (cond && (br_taken_cnt_q != '1)) begin
                br_taken_cnt_q <= br_taken_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.f_pc         = f_pc_q;
    assign bus.f_pc4        = f_pc_q + 32'd4;
    assign bus.taken        = taken_w;
    assign bus.flush_f      = redirect |
                              (LIKELY_EN && bus.likely && is_br && !cond && !bus.stall);
    assign bus.f_adel       = (f_pc_q[1:0] != 2'b00) || (f_pc_q < RESET_PC) ||
                              (f_pc_q > IMEM_END);
    assign bus.br_cnt       = br_cnt_q;
    assign bus.br_taken_cnt = br_taken_cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a default instance and a LIKELY_EN=0, CNT_W=4
// instance share one stimulus stream; expectations are queued and checked per cycle.
module tb_pc_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pc_unit_if #(.CNT_W(16)) ifa ();
    pc_unit_if #(.CNT_W(4))  ifb ();

    pc_unit #(
        .RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180), .IMEM_END(32'h0000_6ffc),
        .LIKELY_EN(1'b1), .CNT_W(16)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    pc_unit #(
        .RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180), .IMEM_END(32'h0000_6ffc),
        .LIKELY_EN(1'b0), .CNT_W(4)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    assign ifb.stall     = ifa.stall;
    assign ifb.d_pc4     = ifa.d_pc4;
    assign ifb.br_type   = ifa.br_type;
    assign ifb.likely    = ifa.likely;
    assign ifb.cmp1      = ifa.cmp1;
    assign ifb.cmp2      = ifa.cmp2;
    assign ifb.imm16     = ifa.imm16;
    assign ifb.jump      = ifa.jump;
    assign ifb.imm26     = ifa.imm26;
    assign ifb.jr        = ifa.jr;
    assign ifb.jr_target = ifa.jr_target;
    assign ifb.exc_req   = ifa.exc_req;
    assign ifb.eret      = ifa.eret;
    assign ifb.epc       = ifa.epc;

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic        fl;
        logic        flb;
        logic        ad;
        logic [15:0] bc;
        logic [15:0] btc;
        logic [3:0]  bcb;
        logic [3:0]  btcb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int unsigned bc_e = 0, btc_e = 0, bcb_e = 0, btcb_e = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("a.f_pc",         ifa.f_pc,                e.pc);
            chk("a.f_pc4",        ifa.f_pc4,               e.pc + 32'd4);
            chk("a.taken",        32'(ifa.taken),          32'(e.tk));
            chk("a.flush_f",      32'(ifa.flush_f),        32'(e.fl));
            chk("a.f_adel",       32'(ifa.f_adel),         32'(e.ad));
            chk("a.br_cnt",       32'(ifa.br_cnt),         32'(e.bc));
            chk("a.br_taken_cnt", 32'(ifa.br_taken_cnt),   32'(e.btc));
            chk("b.f_pc",         ifb.f_pc,                e.pc);
            chk("b.flush_f",      32'(ifb.flush_f),        32'(e.flb));
            chk("b.br_cnt",       32'(ifb.br_cnt),         32'(e.bcb));
            chk("b.br_taken_cnt", 32'(ifb.br_taken_cnt),   32'(e.btcb));
        end
    end

    task automatic clr();
        ifa.stall = 1'b0; ifa.d_pc4 = '0; ifa.br_type = '0; ifa.likely = 1'b0;
        ifa.cmp1 = '0; ifa.cmp2 = '0; ifa.imm16 = '0; ifa.jump = 1'b0;
        ifa.imm26 = '0; ifa.jr = 1'b0; ifa.jr_target = '0; ifa.exc_req = 1'b0;
        ifa.eret = 1'b0; ifa.epc = '0;
    endtask

    // Queue the expected outputs for the current cycle, then cross one edge.
    task automatic step(input logic [31:0] pc, input logic tk, input logic fl,
                        input logic flb, input logic ad, input logic cnt, input logic ctk);
        exp_t e;
        e.pc = pc; e.tk = tk; e.fl = fl; e.flb = flb; e.ad = ad;
        e.bc = bc_e[15:0]; e.btc = btc_e[15:0];
        e.bcb = bcb_e[3:0]; e.btcb = btcb_e[3:0];
        q.push_back(e);
        @(posedge clk); #1;
        if (cnt) begin
            bc_e++;
            if (bcb_e < 15) bcb_e++;
        end
        if (ctk) begin
            btc_e++;
            if (btcb_e < 15) btcb_e++;
        end
    endtask

    logic [2:0]  r_t  [11] = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd3, 3'd6, 3'd2, 3'd1, 3'd7, 3'd1, 3'd6};
    logic [31:0] r_a  [11] = '{32'h0, 32'h1, 32'h8000_0000, 32'h0, 32'hffff_ffff,
                               32'hffff_ffff, 32'h7, 32'h7, 32'h0, 32'h9, 32'h5};
    logic [31:0] r_b  [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'h7, 32'h8, 32'h0, 32'h9, 32'h0};
    logic        r_tk [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin : timeout
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] pc_e;
        reset = 1'b1;
        clr();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Free-running fetch after reset
        step(32'h3000, 0, 0, 0, 0, 0, 0);
        step(32'h3004, 0, 0, 0, 0, 0, 0);
        step(32'h3008, 0, 0, 0, 0, 0, 0);
        step(32'h300c, 0, 0, 0, 0, 0, 0);

        // beq taken backwards below RESET_PC
        ifa.d_pc4 = 32'h3010; ifa.br_type = 3'd1; ifa.cmp1 = 5; ifa.cmp2 = 5; ifa.imm16 = 16'hfffc;
        step(32'h3010, 1, 0, 0, 0, 1, 1);
        clr();
        step(32'h2ffc, 0, 0, 0, 1, 0, 0);

        // Not-taken likely blez: annul only when LIKELY_EN
        ifa.d_pc4 = 32'h3004; ifa.br_type = 3'd3; ifa.likely = 1'b1; ifa.cmp1 = 1;
        step(32'h3000, 0, 1, 0, 0, 1, 0);
        clr();

        // Stalled taken branch holds, then redirects once
        ifa.d_pc4 = 32'h3008; ifa.br_type = 3'd1; ifa.cmp1 = 5; ifa.cmp2 = 5;
        ifa.imm16 = 16'h0004; ifa.stall = 1'b1;
        step(32'h3004, 0, 0, 0, 0, 0, 0);
        step(32'h3004, 0, 0, 0, 0, 0, 0);
        ifa.stall = 1'b0;
        step(32'h3004, 1, 0, 0, 0, 1, 1);
        clr();

        // Exception overrides stall and jump; no count
        ifa.stall = 1'b1; ifa.exc_req = 1'b1; ifa.jump = 1'b1; ifa.imm26 = 26'h0000c40;
        ifa.br_type = 3'd1; ifa.cmp1 = 3; ifa.cmp2 = 3;
        step(32'h3014, 0, 1, 1, 0, 0, 0);
        clr();
        ifa.eret = 1'b1; ifa.epc = 32'h3020;
        step(32'h4180, 0, 1, 1, 0, 0, 0);
        clr();

        // Jump, jr to misaligned address
        ifa.jump = 1'b1; ifa.d_pc4 = 32'h3024; ifa.imm26 = 26'h0000c40;
        step(32'h3020, 1, 0, 0, 0, 0, 0);
        clr();
        ifa.jr = 1'b1; ifa.jr_target = 32'h3002;
        step(32'h3100, 1, 0, 0, 0, 0, 0);
        clr();
        step(32'h3002, 0, 0, 0, 1, 0, 0);

        // Jump and true branch together: jump target, branch still counted
        ifa.jump = 1'b1; ifa.imm26 = 26'h0000c40; ifa.d_pc4 = 32'h3008;
        ifa.br_type = 3'd2; ifa.cmp1 = 1; ifa.cmp2 = 2;
        step(32'h3006, 1, 0, 0, 1, 1, 1);
        clr();

        // Reset wins over stall and exception
        reset = 1'b1; ifa.stall = 1'b1; ifa.exc_req = 1'b1;
        step(32'h3100, 0, 1, 1, 0, 0, 0);
        reset = 1'b0;
        clr();
        bc_e = 0; btc_e = 0; bcb_e = 0; btcb_e = 0;
        step(32'h3000, 0, 0, 0, 0, 0, 0);

        // Branch condition table, target fixed at 0x3004
        pc_e = 32'h3004;
        for (int i = 0; i < 11; i++) begin
            clr();
            ifa.d_pc4 = 32'h3008; ifa.br_type = r_t[i]; ifa.cmp1 = r_a[i]; ifa.cmp2 = r_b[i];
            step(pc_e, r_tk[i], 0, 0, 0, (r_t[i] != 3'd7), r_tk[i]);
            pc_e = r_tk[i] ? 32'h3004 : pc_e + 32'd4;
        end

        // 17 taken bgez to saturate the 4-bit counters
        clr();
        ifa.br_type = 3'd6; ifa.cmp1 = 0; ifa.d_pc4 = pc_e + 32'd4;
        for (int i = 0; i < 17; i++) begin
            step(pc_e, 1, 0, 0, 0, 1, 1);
        end
        clr();
        step(pc_e, 0, 0, 0, 0, 0, 0);
        pc_e = pc_e + 32'd4;

        // jr beyond IMEM_END
        ifa.jr = 1'b1; ifa.jr_target = 32'h7000;
        step(pc_e, 1, 0, 0, 0, 0, 0);
        clr();
        step(32'h7000, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
